// File: rtl/axis_skid_buffer_p.sv
// AXI-Stream register slice with a two-entry skid buffer; every output is a flop.
// Optional beat/packet statistics counters are enabled with `define SKID_STATS_EN.
module axis_skid_buffer_p #(
  parameter int DATA_W = 8,
  parameter int USER_W = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic [USER_W-1:0] s_user,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [USER_W-1:0] m_user,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [1:0]        occupancy,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  pkt_cnt
);

  localparam int PW = DATA_W + USER_W + 1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          s_ready_q, s_ready_d;
  logic          m_valid_q, m_valid_d;

  logic          in_hs;
  logic          out_hs;
  logic [PW-1:0] s_word;

  // One word carries {user, last, data} so the sideband can never slip.
  assign s_word = {s_user, s_last, s_data};
  assign in_hs  = s_valid & s_ready_q;
  assign out_hs = m_valid_q & m_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_hs) begin
          main_d  = s_word;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_hs && out_hs) begin
          main_d = s_word;
        end else if (in_hs) begin
          skid_d  = s_word;
          state_d = ST_FULL;
        end else if (out_hs) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_hs) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flags are derived from the next state so they come straight out of flops.
    m_valid_d = (state_d != ST_EMPTY);
    s_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = main_q[DATA_W-1:0];
  assign m_last    = main_q[DATA_W];
  assign m_user    = main_q[PW-1 -: USER_W];
  assign occupancy = state_q;

`ifdef SKID_STATS_EN
  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] pkt_cnt_q;

  // Clear wins over a same-cycle handshake; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n || stats_clr) begin
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else if (out_hs) begin
      beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      if (m_last) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      end
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign pkt_cnt  = pkt_cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign beat_cnt = '0;
  assign pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_axis_skid_buffer_p.sv
// Self-checking bench for axis_skid_buffer_p: directed vector table, reset corner
// cases, randomised valid/ready scoreboard and statistics counter checks.
module tb_axis_skid_buffer_p;

  localparam int DATA_W = 32;
  localparam int USER_W = 4;
  localparam int CNT_W  = 4;
  localparam int PW     = DATA_W + USER_W + 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [DATA_W-1:0] s_data;
  logic [USER_W-1:0] s_user;
  logic              s_last;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic [USER_W-1:0] m_user;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;
  logic [1:0]        occupancy;
  logic              stats_clr;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  pkt_cnt;

  int tests  = 0;
  int failed = 0;

  axis_skid_buffer_p #(.DATA_W(DATA_W), .USER_W(USER_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_data(s_data), .s_user(s_user), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_user(m_user), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .occupancy(occupancy), .stats_clr(stats_clr), .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s_valid;
    logic [7:0] s_data;
    logic [3:0] s_user;
    logic       s_last;
    logic       m_ready;
    logic       exp_m_valid;
    logic [7:0] exp_m_data;
    logic [3:0] exp_m_user;
    logic       exp_m_last;
    logic       exp_s_ready;
    logic [1:0] exp_occ;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  // Sideband is the inverted low nibble of the payload so user mix-ups show up.
  function automatic vec_t mk(input logic sv, input logic [7:0] sd, input logic sl,
                              input logic mr, input logic ev, input logic [7:0] ed,
                              input logic el, input logic esr, input logic [1:0] eo);
    vec_t v;
    v.s_valid     = sv;
    v.s_data      = sd;
    v.s_user      = ~sd[3:0];
    v.s_last      = sl;
    v.m_ready     = mr;
    v.exp_m_valid = ev;
    v.exp_m_data  = ed;
    v.exp_m_user  = ~ed[3:0];
    v.exp_m_last  = el;
    v.exp_s_ready = esr;
    v.exp_occ     = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [DATA_W-1:0] sd, input logic sl, input logic mr);
    s_valid = sv;
    s_data  = sd;
    s_user  = ~sd[3:0];
    s_last  = sl;
    m_ready = mr;
  endtask

  logic [PW-1:0] sb_q[$];
  logic [PW-1:0] exp_word;
  logic [PW-1:0] held;
  logic          stalled;
  logic          took;
  logic          in_hs;
  logic          out_hs;
  int            outs;
  int            cyc;
  logic [CNT_W-1:0] exp_beat;
  logic [CNT_W-1:0] exp_pkt;

  initial begin
    reset_n   = 1'b0;
    stats_clr = 1'b0;
    drive(1'b1, 32'h77, 1'b0, 1'b1);

    // Streaming 0x01..0x10 at full rate, then drain.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = mk(1'b1, 8'(i + 1), (i == 15), 1'b1, 1'b1, 8'(i + 1), (i == 15), 1'b1, 2'd1);
    end
    vecs[16] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 2'd0);
    // Backpressure: A1 lands in the skid, A2 waits for s_ready.
    vecs[17] = mk(1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 1'b1, 2'd1);
    vecs[18] = mk(1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 2'd2);
    vecs[19] = mk(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 2'd2);
    vecs[20] = mk(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 2'd2);
    vecs[21] = mk(1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b1, 2'd1);
    vecs[22] = mk(1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b1, 2'd1);
    vecs[23] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, 2'd0);

    // Reset held three cycles with s_valid asserted.
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_m_valid", m_valid, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_data", m_data, 0);
      check("rst_occ", occupancy, 0);
      $display("[TB] reset cycle %0d m_valid=%0b s_ready=%0b", i, m_valid, s_ready);
    end
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    check("rel_s_ready", s_ready, 1);
    check("rel_m_valid", m_valid, 0);

    for (int i = 0; i < NVEC; i++) begin
      s_valid = vecs[i].s_valid;
      s_data  = {24'h0, vecs[i].s_data};
      s_user  = vecs[i].s_user;
      s_last  = vecs[i].s_last;
      m_ready = vecs[i].m_ready;
      tick();
      check("vec_m_valid", m_valid, vecs[i].exp_m_valid);
      check("vec_m_data", m_data, {24'h0, vecs[i].exp_m_data});
      check("vec_m_user", m_user, vecs[i].exp_m_user);
      check("vec_m_last", m_last, vecs[i].exp_m_last);
      check("vec_s_ready", s_ready, vecs[i].exp_s_ready);
      check("vec_occ", occupancy, vecs[i].exp_occ);
      $display("[TB] vec %0d in=%0h m_valid=%0b m_data=%0h occ=%0d", i, vecs[i].s_data,
               m_valid, m_data, occupancy);
    end

    // Reset while FULL discards both held beats.
    drive(1'b1, 32'hA8, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hA9, 1'b0, 1'b0);
    tick();
    check("mid_pre_occ", occupancy, 2);
    reset_n = 1'b0;
    drive(1'b1, 32'hAA, 1'b0, 1'b0);
    tick();
    check("mid_m_valid", m_valid, 0);
    check("mid_occ", occupancy, 0);
    check("mid_s_ready", s_ready, 0);
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    check("mid_rel_s_ready", s_ready, 1);
    check("mid_rel_m_valid", m_valid, 0);
    drive(1'b1, 32'h55, 1'b0, 1'b1);
    tick();
    check("mid_55", {m_valid, m_data}, {1'b1, 32'h55});
    drive(1'b1, 32'h66, 1'b1, 1'b1);
    tick();
    check("mid_66", {m_valid, m_last, m_data}, {1'b1, 1'b1, 32'h66});
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    check("mid_drain", {m_valid, occupancy}, {1'b0, 2'd0});
    $display("[TB] mid-operation reset sequence done");

    // Random valid/ready with a FIFO scoreboard and stall stability checks.
    outs = 0;
    cyc  = 0;
    took = 1'b0;
    s_valid = 1'b0;
    while (outs < 10000 && cyc < 60000) begin
      if (!s_valid || took) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = $urandom;
        s_user  = 4'($urandom_range(0, 15));
        s_last  = ($urandom_range(0, 3) == 0);
      end
      m_ready = 1'($urandom_range(0, 1));
      in_hs   = s_valid & s_ready;
      out_hs  = m_valid & m_ready;
      if (out_hs) begin
        if (sb_q.size() == 0) begin
          check("rand_unexpected_beat", {m_user, m_last, m_data}, 0);
        end else begin
          exp_word = sb_q.pop_front();
          check("rand_beat", {m_user, m_last, m_data}, exp_word);
        end
        outs++;
      end
      if (in_hs) sb_q.push_back({s_user, s_last, s_data});
      stalled = m_valid & ~m_ready;
      held    = {m_user, m_last, m_data};
      tick();
      cyc++;
      if (stalled) check("rand_stall_stable", {m_valid, m_user, m_last, m_data}, {1'b1, held});
      took = in_hs;
    end
    check("rand_budget", outs, 10000);
    $display("[TB] random phase: %0d beats out in %0d cycles", outs, cyc);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m_valid) begin
        if (sb_q.size() != 0) begin
          exp_word = sb_q.pop_front();
          check("drain_beat", {m_user, m_last, m_data}, exp_word);
        end else begin
          check("drain_extra_beat", m_valid, 0);
        end
      end
      tick();
    end
    check("drain_sb_empty", sb_q.size(), 0);
    check("drain_m_valid", m_valid, 0);

    // Statistics: 17 beats in 3 packets with a 4-bit counter.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'(i), (i == 4 || i == 10 || i == 16), 1'b1);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
`ifdef SKID_STATS_EN
    exp_beat = 4'd1;
    exp_pkt  = 4'd3;
`else
    exp_beat = 4'd0;
    exp_pkt  = 4'd0;
`endif
    check("stats_beat_wrap", beat_cnt, exp_beat);
    check("stats_pkt", pkt_cnt, exp_pkt);
    $display("[TB] stats after 17 beats: beat_cnt=%0d pkt_cnt=%0d", beat_cnt, pkt_cnt);
    drive(1'b1, 32'h99, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("stats_clr_beat", beat_cnt, 0);
    check("stats_clr_pkt", pkt_cnt, 0);
    drive(1'b1, 32'h42, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
`ifdef SKID_STATS_EN
    exp_beat = 4'd1;
`else
    exp_beat = 4'd0;
`endif
    check("stats_post_clr_beat", beat_cnt, exp_beat);
    check("stats_post_clr_pkt", pkt_cnt, 0);
    $display("[TB] stats after clear: beat_cnt=%0d pkt_cnt=%0d", beat_cnt, pkt_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
